video_stream_monitor: RTL

Multi-channel, passive AXI-Stream video statistics monitor. It is the successor to the single-channel frame-rate counter. It sits behind the existing axi_lite_slave, connected through its simple register interface, and taps NUM_CHANNELS video streams without ever driving tready. Per channel it measures frames, FPS, lines per frame, pixels per line, and min/max line length, and flags geometry errors through sticky status bits and an interrupt.

---
 rtl/video_stream_monitor_pkg.sv | 48 ++++
 rtl/vsm_channel.sv | 125 ++++++++++++
 rtl/video_stream_monitor.sv | 132 +++++++++++++
 3 files changed

// File: rtl/video_stream_monitor_pkg.sv
// Shared constants and types for the multi-channel AXI-Stream video statistics monitor.
package video_stream_monitor_pkg;

   localparam int unsigned VSM_CH_STRIDE  = 32'h20;
   localparam int unsigned VSM_BANK_SHIFT = $clog2(VSM_CH_STRIDE);

   // global register offsets (bank 0)
   localparam logic [4:0] REG_CONTROL    = 5'h00;
   localparam logic [4:0] REG_VERSION    = 5'h04;
   localparam logic [4:0] REG_WINDOW     = 5'h08;
   localparam logic [4:0] REG_IRQ_STATUS = 5'h0C;

   // channel bank offsets
   localparam logic [4:0] CH_STATUS       = 5'h00;
   localparam logic [4:0] CH_TOTAL_FRAMES = 5'h04;
   localparam logic [4:0] CH_FPS          = 5'h08;
   localparam logic [4:0] CH_LINES        = 5'h0C;
   localparam logic [4:0] CH_PIXELS       = 5'h10;
   localparam logic [4:0] CH_MIN_LINE     = 5'h14;
   localparam logic [4:0] CH_MAX_LINE     = 5'h18;
   localparam logic [4:0] CH_FRAME_PERIOD = 5'h1C;

   localparam int unsigned ST_FRAME_SEEN = 0;
   localparam int unsigned ST_LEN_MISM   = 1;
   localparam int unsigned ST_LINE_MISM  = 2;
   localparam int unsigned ST_EARLY_SOF  = 3;
   localparam int unsigned ST_OVERFLOW   = 4;

   localparam logic [7:0] VSM_VER_MAJOR = 8'd2;
   localparam logic [7:0] VSM_VER_MINOR = 8'd0;
   localparam logic [7:0] VSM_VER_REV   = 8'd1;

   typedef struct packed {
      logic [4:0]  status;
      logic [31:0] total_frames;
      logic [31:0] fps;
      logic [31:0] lines_per_frame;
      logic [31:0] pixels_per_line;
      logic [31:0] min_line;
      logic [31:0] max_line;
      logic [31:0] frame_period;
   } vsm_stats_t;

   function automatic logic [31:0] vsm_version();
      return {8'h00, VSM_VER_MAJOR, VSM_VER_MINOR, VSM_VER_REV};
   endfunction

endpackage

// File: rtl/vsm_channel.sv
// Per-channel frame/line statistics and sticky error tracking.
// VSM_FRAME_PERIOD_EN adds the SOF-to-SOF cycle counter behind FRAME_PERIOD.
module vsm_channel
   import video_stream_monitor_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clear,
   input  logic       i_tvalid,
   input  logic       i_tready,
   input  logic       i_tlast,
   input  logic       i_tuser,
   input  logic       i_win_tc,
   input  logic [4:0] i_status_w1c,
   output vsm_stats_t o_stats,
   output logic       o_err_rise
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [CNT_WIDTH-1:0] r_pix, r_line, r_ppl, r_lpf, r_min, r_max;
   logic                 r_ppl_vld, r_lpf_vld, r_armed;
   logic [4:0]           r_status;
   logic [31:0]          r_frames, r_fps_cnt, r_fps;

   logic                 w_beat, w_sof, w_eol;
   logic [CNT_WIDTH-1:0] w_pix_base, w_len, w_line_base, w_line_inc;
   logic [4:0]           w_set;

   always_comb begin
      w_beat      = i_tvalid & i_tready;
      w_sof       = w_beat & i_tuser;
      w_eol       = w_beat & i_tlast;
      // a SOF beat counts as pixel 1, so the pre-beat base is 0; len covers the current beat
      w_pix_base  = w_sof ? '0 : r_pix;
      w_len       = (w_pix_base == CNT_MAX) ? CNT_MAX : w_pix_base + 1'b1;
      w_line_base = (w_sof) ? '0 : r_line;
      w_line_inc  = (w_line_base == CNT_MAX) ? CNT_MAX : w_line_base + 1'b1;
      w_set                = '0;
      w_set[ST_FRAME_SEEN] = w_sof;
      w_set[ST_LEN_MISM]   = w_eol & r_ppl_vld & (w_len != r_ppl);
      w_set[ST_LINE_MISM]  = w_sof & r_armed & r_lpf_vld & (r_line != r_lpf);
      w_set[ST_EARLY_SOF]  = w_sof & (r_pix != '0);
      w_set[ST_OVERFLOW]   = (w_beat & (w_pix_base == CNT_MAX)) |
                             (w_eol & (w_line_base == CNT_MAX));
      o_err_rise           = |(w_set[4:1] & ~r_status[4:1]);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pix <= '0; r_line <= '0; r_ppl <= '0; r_lpf <= '0;
         r_min <= '1; r_max <= '0;
         r_ppl_vld <= 1'b0; r_lpf_vld <= 1'b0; r_armed <= 1'b0;
         r_status <= '0; r_frames <= '0; r_fps_cnt <= '0; r_fps <= '0;
      end else if (i_clear) begin
         r_pix <= '0; r_line <= '0; r_ppl <= '0; r_lpf <= '0;
         r_min <= '1; r_max <= '0;
         r_ppl_vld <= 1'b0; r_lpf_vld <= 1'b0; r_armed <= 1'b0;
         r_status <= '0; r_frames <= '0; r_fps_cnt <= '0; r_fps <= '0;
      end else begin
         r_status <= (r_status & ~i_status_w1c) | w_set;
         if (w_eol) begin
            r_pix     <= '0;
            r_line    <= w_line_inc;
            r_ppl     <= w_len;
            r_ppl_vld <= 1'b1;
            if (w_len < r_min) r_min <= w_len;
            if (w_len > r_max) r_max <= w_len;
         end else begin
            if (w_beat) r_pix <= w_len;
            r_line <= w_line_base;
         end
         if (w_sof) begin
            r_frames <= r_frames + 32'd1;
            r_armed  <= 1'b1;
            if (r_armed) begin
               r_lpf     <= r_line;
               r_lpf_vld <= 1'b1;
            end
         end
         if (i_win_tc) begin
            r_fps     <= r_fps_cnt;
            r_fps_cnt <= {31'd0, w_sof};
         end else if (w_sof) begin
            r_fps_cnt <= r_fps_cnt + 32'd1;
         end
      end
   end

`ifdef VSM_FRAME_PERIOD_EN
   logic [31:0] r_fp_cnt, r_fp;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fp_cnt <= '0;
         r_fp     <= '0;
      end else if (i_clear) begin
         r_fp_cnt <= '0;
         r_fp     <= '0;
      end else if (w_sof) begin
         r_fp_cnt <= 32'd1;
         if (r_armed) r_fp <= r_fp_cnt;
      end else if (r_fp_cnt != '1) begin
         r_fp_cnt <= r_fp_cnt + 32'd1;
      end
   end
`endif

   always_comb begin
      o_stats                 = '0;
      o_stats.status          = r_status;
      o_stats.total_frames    = r_frames;
      o_stats.fps             = r_fps;
      o_stats.lines_per_frame = 32'(r_lpf);
      o_stats.pixels_per_line = 32'(r_ppl);
      o_stats.min_line        = 32'(r_min);
      o_stats.max_line        = 32'(r_max);
`ifdef VSM_FRAME_PERIOD_EN
      o_stats.frame_period    = r_fp;
`endif
   end

endmodule

// File: rtl/video_stream_monitor.sv
// Passive multi-channel AXI-Stream video statistics monitor: register decode, FPS window, IRQ.
// VSM_FRAME_PERIOD_EN enables the per-channel FRAME_PERIOD measurement.
module video_stream_monitor
   import video_stream_monitor_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 16,
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned CNT_WIDTH    = 16,
   parameter int unsigned CLOCK_PERIOD = 100000000
) (
   input  logic                    i_axi_clk,
   input  logic                    i_axi_rst,
   input  logic [ADDR_WIDTH-1:0]   i_reg_address,
   input  logic                    i_reg_in_rdy,
   input  logic [31:0]             i_reg_in_data,
   output logic                    o_reg_in_ack,
   input  logic                    i_reg_out_req,
   output logic                    o_reg_out_rdy,
   output logic [31:0]             o_reg_out_data,
   output logic                    o_reg_invalid_addr,
   input  logic [NUM_CHANNELS-1:0] i_axis_tvalid,
   input  logic [NUM_CHANNELS-1:0] i_axis_tready,
   input  logic [NUM_CHANNELS-1:0] i_axis_tlast,
   input  logic [NUM_CHANNELS-1:0] i_axis_tuser,
   output logic                    o_irq
);

   logic                    r_irq_en, r_clear;
   logic [31:0]             r_window, r_win_cnt;
   logic [NUM_CHANNELS-1:0] r_irq_status;

   logic                    w_wr, w_rd, w_valid, w_win_tc;
   logic                    w_wr_ctrl, w_wr_win, w_wr_irq;
   logic [ADDR_WIDTH-1:0]   w_bank;
   logic [4:0]              w_off;
   logic [31:0]             w_rdata;
   logic [NUM_CHANNELS-1:0] w_err_rise;
   logic [4:0]              w_ch_w1c [NUM_CHANNELS];
   vsm_stats_t              w_stats  [NUM_CHANNELS];

   // write wins a simultaneous request; the read follows while req stays high
   assign w_wr     = i_reg_in_rdy & ~o_reg_in_ack;
   assign w_rd     = i_reg_out_req & ~w_wr & ~o_reg_out_rdy;
   assign w_win_tc = (r_window != '0) && (r_win_cnt >= r_window - 32'd1);

   always_comb begin
      w_bank    = i_reg_address >> VSM_BANK_SHIFT;
      w_off     = i_reg_address[VSM_BANK_SHIFT-1:0];
      w_valid   = 1'b0;
      w_rdata   = '0;
      w_wr_ctrl = 1'b0;
      w_wr_win  = 1'b0;
      w_wr_irq  = 1'b0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) w_ch_w1c[c] = '0;
      if (w_off[1:0] == 2'b00) begin
         if (w_bank == '0) begin
            case (w_off)
               REG_CONTROL:    begin w_valid = 1'b1; w_rdata = {30'd0, r_irq_en, 1'b0}; w_wr_ctrl = w_wr; end
               REG_VERSION:    begin w_valid = 1'b1; w_rdata = vsm_version(); end
               REG_WINDOW:     begin w_valid = 1'b1; w_rdata = r_window; w_wr_win = w_wr; end
               REG_IRQ_STATUS: begin w_valid = 1'b1; w_rdata = 32'(r_irq_status); w_wr_irq = w_wr; end
               default: ;
            endcase
         end else begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
               if (w_bank == ADDR_WIDTH'(c + 1)) begin
                  w_valid = 1'b1;
                  case (w_off)
                     CH_STATUS:       w_rdata = {27'd0, w_stats[c].status};
                     CH_TOTAL_FRAMES: w_rdata = w_stats[c].total_frames;
                     CH_FPS:          w_rdata = w_stats[c].fps;
                     CH_LINES:        w_rdata = w_stats[c].lines_per_frame;
                     CH_PIXELS:       w_rdata = w_stats[c].pixels_per_line;
                     CH_MIN_LINE:     w_rdata = w_stats[c].min_line;
                     CH_MAX_LINE:     w_rdata = w_stats[c].max_line;
                     CH_FRAME_PERIOD: w_rdata = w_stats[c].frame_period;
                     default: ;
                  endcase
                  if (w_wr && w_off == CH_STATUS) w_ch_w1c[c] = i_reg_in_data[4:0];
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
      vsm_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
         .i_clk        (i_axi_clk),
         .i_rst_n      (i_axi_rst),
         .i_clear      (r_clear),
         .i_tvalid     (i_axis_tvalid[g]),
         .i_tready     (i_axis_tready[g]),
         .i_tlast      (i_axis_tlast[g]),
         .i_tuser      (i_axis_tuser[g]),
         .i_win_tc     (w_win_tc),
         .i_status_w1c (w_ch_w1c[g]),
         .o_stats      (w_stats[g]),
         .o_err_rise   (w_err_rise[g])
      );
   end

   always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
      if (!i_axi_rst) begin
         o_reg_in_ack       <= 1'b0;
         o_reg_out_rdy      <= 1'b0;
         o_reg_out_data     <= '0;
         o_reg_invalid_addr <= 1'b0;
         o_irq              <= 1'b0;
         r_irq_en           <= 1'b0;
         r_clear            <= 1'b0;
         r_window           <= CLOCK_PERIOD;
         r_win_cnt          <= '0;
         r_irq_status       <= '0;
      end else begin
         o_reg_in_ack       <= w_wr;
         o_reg_out_rdy      <= w_rd;
         o_reg_out_data     <= w_rd ? w_rdata : '0;
         o_reg_invalid_addr <= (w_wr | w_rd) & ~w_valid;
         o_irq              <= r_irq_en & (|r_irq_status);
         r_clear            <= w_wr_ctrl & i_reg_in_data[0];
         if (w_wr_ctrl) r_irq_en <= i_reg_in_data[1];
         if (w_wr_win)  r_window <= i_reg_in_data;
         if (w_wr_win || r_clear)  r_win_cnt <= '0;
         else if (w_win_tc)        r_win_cnt <= '0;
         else if (r_window != '0)  r_win_cnt <= r_win_cnt + 32'd1;
         if (r_clear) r_irq_status <= '0;
         else r_irq_status <= (r_irq_status &
                               ~(w_wr_irq ? i_reg_in_data[NUM_CHANNELS-1:0] : '0)) | w_err_rise;
      end
   end

endmodule
